// File: rtl/kronecker_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kronecker_pipe_if : share/valid bus of the masked Kronecker pipe    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface kronecker_pipe_if #(
   parameter int WIDTH = 8,
   parameter int ORDER = 1
);
   localparam int SHARES = ORDER + 1;
   localparam int RPG    = ORDER * (ORDER + 1) / 2;
   localparam int RAND_W = (WIDTH - 1) * RPG;

   logic                      in_valid;
   logic [SHARES*WIDTH-1:0]   inp;
   // "rand" is reserved in SystemVerilog, hence rnd
   logic [RAND_W-1:0]         rnd;
   logic [SHARES-1:0]         Z;
   logic                      out_valid;

   modport master (
      output in_valid, inp, rnd,
      input  Z, out_valid
   );

   modport slave (
      input  in_valid, inp, rnd,
      output Z, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/kronecker_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kronecker_pipe : pipelined masked equality (x == TARGET) detector   |
// | built from a binary tree of DOM-indep AND gadgets. Revision 1.0     |
// +--------------------------------------------------------------------+

module kronecker_dom_and #(
   parameter int SHARES = 2,
   parameter int RPG    = SHARES * (SHARES - 1) / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SHARES-1:0] a,
   input  logic [SHARES-1:0] b,
   input  logic [RPG-1:0]    rnd,
   output logic [SHARES-1:0] q
);
   // [domain][partner]: every product is registered before compression
   logic [SHARES-1:0][SHARES-1:0] w_term;
   logic [SHARES-1:0][SHARES-1:0] r_term;

   for (genvar i = 0; i < SHARES; i++) begin : g_dom
      for (genvar j = 0; j < SHARES; j++) begin : g_term
         if (i == j) begin : g_inner
            assign w_term[i][j] = a[i] & b[j];
         end else begin : g_cross
            // both mirror terms of pair (LO,HI) share one fresh bit
            localparam int LO   = (i < j) ? i : j;
            localparam int HI   = (i < j) ? j : i;
            localparam int RIDX = LO * SHARES - (LO * (LO + 1)) / 2 + (HI - LO - 1);
            assign w_term[i][j] = (a[i] & b[j]) ^ rnd[RIDX];
         end
      end
      assign q[i] = ^r_term[i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_term <= '0;
      end else begin
         r_term <= w_term;
      end
   end
endmodule

module kronecker_pipe #(
   parameter int               WIDTH  = 8,
   parameter int               ORDER  = 1,
   parameter logic [WIDTH-1:0] TARGET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   kronecker_pipe_if.slave  bus
);
   localparam int SHARES = ORDER + 1;
   localparam int LEVELS = $clog2(WIDTH);
   localparam int GATES  = WIDTH - 1;
   localparam int RPG    = ORDER * (ORDER + 1) / 2;
   localparam int RAND_W = GATES * RPG;
   // nodes 0..WIDTH-1 are leaves, node WIDTH+g is the output of gadget g
   localparam int NODES  = WIDTH + GATES;

   logic [SHARES-1:0] w_node [NODES];
   logic [LEVELS-1:0] r_valid;

   // Leaf i encodes x[i] XNOR TARGET[i]; only the top share is touched
   for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
      logic [SHARES-1:0] w_sh;
      for (genvar s = 0; s < SHARES; s++) begin : g_share
         if (s == SHARES - 1) begin : g_last
            assign w_sh[s] = bus.inp[s*WIDTH+i] ^ ~TARGET[i];
         end else begin : g_pass
            assign w_sh[s] = bus.inp[s*WIDTH+i];
         end
      end
      assign w_node[i] = w_sh;
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int NG    = WIDTH >> (l + 1);
      localparam int GBASE = WIDTH - (WIDTH >> l);
      localparam int IBASE = 2 * WIDTH - ((2 * WIDTH) >> l);
      for (genvar k = 0; k < NG; k++) begin : g_gate
         kronecker_dom_and #(
            .SHARES (SHARES),
            .RPG    (RPG)
         ) u_and (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (w_node[IBASE+2*k]),
            .b     (w_node[IBASE+2*k+1]),
            .rnd   (bus.rnd[(GBASE+k)*RPG +: RPG]),
            .q     (w_node[WIDTH+GBASE+k])
         );
      end
   end

   // Data flows every cycle; only the valid flag is tracked alongside
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= bus.in_valid;
         for (int l = 1; l < LEVELS; l++) begin
            r_valid[l] <= r_valid[l-1];
         end
      end
   end

   assign bus.Z         = w_node[NODES-1];
   assign bus.out_valid = r_valid[LEVELS-1];

   logic [RAND_W-1:0] w_rnd_chk;
   assign w_rnd_chk = bus.rnd;
   logic w_unused;
   assign w_unused = ^w_rnd_chk;
endmodule
`default_nettype wire

// File: tb/tb_kronecker_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_kronecker_pipe : directed self-checking bench for kronecker_pipe |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_kronecker_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   zero_rand = 1'b0;

   kronecker_pipe_if #(.WIDTH(8),  .ORDER(1)) bus8  ();
   kronecker_pipe_if #(.WIDTH(8),  .ORDER(1)) busa5 ();
   kronecker_pipe_if #(.WIDTH(16), .ORDER(2)) bus16 ();

   kronecker_pipe #(.WIDTH(8), .ORDER(1), .TARGET(8'h00)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8));
   kronecker_pipe #(.WIDTH(8), .ORDER(1), .TARGET(8'hA5)) u_duta5 (
      .clk(clk), .rst_n(rst_n), .bus(busa5));
   kronecker_pipe #(.WIDTH(16), .ORDER(2), .TARGET(16'h0000)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16));

   // advance one cycle, then refresh randomness for the next edge
   task automatic tick();
      logic [63:0] t;
      @(posedge clk);
      #1;
      t = {$urandom, $urandom};
      bus8.rnd  = zero_rand ? 7'd0 : t[6:0];
      busa5.rnd = t[13:7];
      t = {$urandom, $urandom};
      bus16.rnd = t[44:0];
   endtask

   function automatic logic [15:0] mask8(input logic [7:0] x);
      logic [7:0] m;
      m = 8'($urandom);
      return {x ^ m, m};
   endfunction

   function automatic logic [47:0] mask16(input logic [15:0] x);
      logic [15:0] m0, m1;
      m0 = 16'($urandom);
      m1 = 16'($urandom);
      return {x ^ m0 ^ m1, m1, m0};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid8 got %b want 0", bus8.out_valid); end
      n_cmp++; if (bus8.Z !== 2'b00) begin n_bad++; $display("FAIL reset_z8 got %b want 00", bus8.Z); end
      n_cmp++; if (busa5.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valida5 got %b want 0", busa5.out_valid); end
      n_cmp++; if (busa5.Z !== 2'b00) begin n_bad++; $display("FAIL reset_za5 got %b want 00", busa5.Z); end
      n_cmp++; if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid16 got %b want 0", bus16.out_valid); end
      n_cmp++; if (bus16.Z !== 3'b000) begin n_bad++; $display("FAIL reset_z16 got %b want 000", bus16.Z); end
      rst_n = 1'b1;
   endtask

   task automatic test_delta_zero();
      bus8.inp      = mask8(8'h00);
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            bus8.inp = mask8(8'h5A);
            tick();
         end
         n_cmp++;
         if (bus8.out_valid !== (c == 2)) begin
            n_bad++; $display("FAIL delta0_valid c=%0d got %b want %b", c, bus8.out_valid, (c == 2));
         end
         if (c == 2) begin
            n_cmp++;
            if ((^bus8.Z) !== 1'b1) begin n_bad++; $display("FAIL delta0_z got %b want 1", ^bus8.Z); end
         end
      end
   endtask

   task automatic test_nonzero();
      logic [7:0] xs [4];
      logic       ex [4];
      xs = '{8'h01, 8'h80, 8'hFF, 8'h7F};
      ex = '{1'b0, 1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 7; c++) begin
         bus8.in_valid = (c < 4);
         bus8.inp      = mask8((c < 4) ? xs[c] : 8'h00);
         tick();
         n_cmp++;
         if (bus8.out_valid !== (c >= 2 && c < 6)) begin
            n_bad++; $display("FAIL nonzero_valid c=%0d got %b", c, bus8.out_valid);
         end
         if (c >= 2 && c < 6) begin
            n_cmp++;
            if ((^bus8.Z) !== ex[c-2]) begin
               n_bad++; $display("FAIL nonzero_z x=%h got %b want %b", xs[c-2], ^bus8.Z, ex[c-2]);
            end
         end
      end
      bus8.in_valid = 1'b0;
   endtask

   task automatic test_sweep();
      for (int c = 0; c < 259; c++) begin
         bus8.in_valid = (c < 256);
         bus8.inp      = mask8(8'(c));
         tick();
         n_cmp++;
         if (bus8.out_valid !== (c >= 2 && c < 258)) begin
            n_bad++; $display("FAIL sweep_valid c=%0d got %b", c, bus8.out_valid);
         end
         if (c >= 2 && c < 258) begin
            n_cmp++;
            if ((^bus8.Z) !== (c == 2)) begin
               n_bad++; $display("FAIL sweep_z x=%h got %b want %b", 8'(c - 2), ^bus8.Z, (c == 2));
            end
         end
      end
      bus8.in_valid = 1'b0;
   endtask

   task automatic test_target();
      logic [7:0] xs [3];
      logic       ex [3];
      xs = '{8'hA5, 8'hA4, 8'h00};
      ex = '{1'b1, 1'b0, 1'b0};
      for (int c = 0; c < 6; c++) begin
         busa5.in_valid = (c < 3);
         busa5.inp      = mask8((c < 3) ? xs[c] : 8'h3C);
         tick();
         n_cmp++;
         if (busa5.out_valid !== (c >= 2 && c < 5)) begin
            n_bad++; $display("FAIL target_valid c=%0d got %b", c, busa5.out_valid);
         end
         if (c >= 2 && c < 5) begin
            n_cmp++;
            if ((^busa5.Z) !== ex[c-2]) begin
               n_bad++; $display("FAIL target_z x=%h got %b want %b", xs[c-2], ^busa5.Z, ex[c-2]);
            end
         end
      end
      busa5.in_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 3; c++) begin
         bus8.in_valid = 1'b1;
         bus8.inp      = mask8(8'h00);
         if (c == 2) rst_n = 1'b0;
         tick();
      end
      rst_n         = 1'b1;
      bus8.in_valid = 1'b0;
      n_cmp++; if (bus8.Z !== 2'b00) begin n_bad++; $display("FAIL midrst_z got %b want 00", bus8.Z); end
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid0 got %b want 0", bus8.out_valid); end
      for (int c = 0; c < 4; c++) begin
         bus8.inp = mask8(8'h00);
         tick();
         n_cmp++;
         if (bus8.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_valid c=%0d got %b want 0", c, bus8.out_valid);
         end
      end
   endtask

   task automatic test_w16_order2();
      localparam int N = 10000;
      bit          exp16 [N];
      logic [15:0] x;
      for (int c = 0; c < N + 4; c++) begin
         if (c < N) begin
            x        = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
            exp16[c] = (x == 16'h0000);
         end else begin
            x = 16'h1234;
         end
         bus16.in_valid = (c < N);
         bus16.inp      = mask16(x);
         tick();
         n_cmp++;
         if (bus16.out_valid !== (c >= 3 && c < N + 3)) begin
            n_bad++; $display("FAIL w16_valid c=%0d got %b", c, bus16.out_valid);
         end
         if (c >= 3 && c < N + 3) begin
            n_cmp++;
            if ((^bus16.Z) !== exp16[c-3]) begin
               n_bad++; $display("FAIL w16_z idx=%0d got %b want %b", c - 3, ^bus16.Z, exp16[c-3]);
            end
         end
      end
      bus16.in_valid = 1'b0;
   endtask

   task automatic test_masking();
      localparam int N = 10000;
      int ones;
      zero_rand = 1'b1;
      bus8.rnd  = 7'd0;
      for (int c = 0; c < 6; c++) begin
         bus8.in_valid = (c < 4);
         bus8.inp      = mask8(8'h00);
         tick();
         if (c >= 2 && c < 6) begin
            n_cmp++;
            if (bus8.out_valid !== 1'b1 || (^bus8.Z) !== 1'b1) begin
               n_bad++; $display("FAIL zrand_z c=%0d got v=%b z=%b want v=1 z=1", c, bus8.out_valid, ^bus8.Z);
            end
         end
      end
      zero_rand = 1'b0;
      ones      = 0;
      for (int c = 0; c < N + 2; c++) begin
         bus8.in_valid = (c < N);
         bus8.inp      = mask8(8'h00);
         tick();
         if (c >= 2) begin
            n_cmp++;
            if (bus8.out_valid !== 1'b1 || (^bus8.Z) !== 1'b1) begin
               n_bad++; $display("FAIL rrand_z c=%0d got v=%b z=%b want v=1 z=1", c, bus8.out_valid, ^bus8.Z);
            end
            if (bus8.Z[0] === 1'b1) ones++;
         end
      end
      bus8.in_valid = 1'b0;
      n_cmp++;
      if (ones < 4500 || ones > 5500) begin
         n_bad++; $display("FAIL share_balance got %0d ones want 4500..5500 of %0d", ones, N);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus8.in_valid  = 1'b0;  bus8.inp  = '0; bus8.rnd  = '0;
      busa5.in_valid = 1'b0;  busa5.inp = '0; busa5.rnd = '0;
      bus16.in_valid = 1'b0;  bus16.inp = '0; bus16.rnd = '0;
      test_reset();
      test_delta_zero();
      test_nonzero();
      test_sweep();
      test_target();
      test_reset_midflight();
      test_delta_zero();
      test_w16_order2();
      test_masking();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
